serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor with a start/busy/done handshake. It adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a registered carry. It is the area-minimal sequential successor to the combinational half/full adder cells in the arithmetic library. It provides carry-out and signed overflow, and targets datapaths where latency can be traded for gates.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder_full_adder.sv | 25 ++
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the adder family: FSM state encodings and
// arithmetic constants used by the serial adder and its neighbours.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int   ADDER_DEFAULT_WIDTH = 8;
  localparam logic SUB_CARRY_IN        = 1'b1;

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle between a requester and the serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit adder cells: a half adder and a full adder composed from two of them.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i;
  assign cout_o = a_i & b_i;
endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic s1, c1, c2;

  halfadder u_ha0 (.a_i(a_i), .b_i(b_i),   .sum_o(s1),    .cout_o(c1));
  halfadder u_ha1 (.a_i(s1),  .b_i(cin_i), .sum_o(sum_o), .cout_o(c2));

  assign cout_o = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, a registered carry and
// LSB-first shift registers. Results stay on sum/cout/ovf until the next
// operation finishes, so the working sum register is kept separate.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus_if
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_cout;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_cout)
  );

  assign accept   = bus_if.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

  // State register, cleared asynchronously so an aborted operation leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_if.start) state_d = RUN;
      RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
      DONE:    state_d = bus_if.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on accept, shift one bit per RUN cycle.
  // On the last bit carry_q is the carry into the MSB, so overflow is
  // that carry XOR the carry leaving the MSB.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = bus_if.a;
      b_d     = bus_if.sub ? ~bus_if.b : bus_if.b;
      carry_d = bus_if.sub ? SUB_CARRY_IN : bus_if.cin;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == RUN) begin
      acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = fa_cout;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_bit) begin
        sum_d  = {fa_sum, acc_q[WIDTH-1:1]};
        cout_d = fa_cout;
        ovf_d  = carry_q ^ fa_cout;
      end
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_if.busy = (state_q == RUN);
  assign bus_if.done = (state_q == DONE);
  assign bus_if.sum  = sum_q;
  assign bus_if.cout = cout_q;
  assign bus_if.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with hand-computed results.
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_if #(.WIDTH(W)) sif ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(sif.slave)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for one edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic subIn, input logic cinIn,
                               input logic [W-1:0] aIn, input logic [W-1:0] bIn);
    sif.start = 1'b1;
    sif.sub   = subIn;
    sif.cin   = cinIn;
    sif.a     = aIn;
    sif.b     = bIn;
    tick();
    sif.start = 1'b0;
  endtask

  // Wait (bounded) for done, counting busy samples and busy/done overlap.
  task automatic waitDone(output int edges, output int busyCount, output int overlap);
    edges     = 0;
    busyCount = 0;
    overlap   = 0;
    while (sif.done !== 1'b1 && edges < 40) begin
      if (sif.busy === 1'b1) busyCount++;
      if (sif.busy === 1'b1 && sif.done === 1'b1) overlap++;
      tick();
      edges++;
    end
    if (sif.busy === 1'b1 && sif.done === 1'b1) overlap++;
  endtask

  // Full operation with timing and result checks.
  task automatic runOp(input string tag, input logic subIn, input logic cinIn,
                       input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                       input logic [W-1:0] expSum, input logic expCout,
                       input logic expOvf);
    int edges, busyCount, overlap;
    applyStimulus(subIn, cinIn, aIn, bIn);
    waitDone(edges, busyCount, overlap);
    checkOutput({tag, "_latency"}, edges, 8);
    checkOutput({tag, "_busy_cycles"}, busyCount, 8);
    checkOutput({tag, "_overlap"}, overlap, 0);
    checkOutput({tag, "_sum"}, sif.sum, expSum);
    checkOutput({tag, "_cout"}, sif.cout, expCout);
    checkOutput({tag, "_ovf"}, sif.ovf, expOvf);
    tick();
    checkOutput({tag, "_done_pulse"}, sif.done, 1'b0);
    checkOutput({tag, "_sum_held"}, sif.sum, expSum);
  endtask

  initial begin
    int edges, busyCount, overlap;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    sif.start = 1'b0;
    sif.sub   = 1'b0;
    sif.cin   = 1'b0;
    sif.a     = '0;
    sif.b     = '0;

    // Reset held for three cycles, released away from the active edge.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_busy", sif.busy, 1'b0);
    checkOutput("rst_done", sif.done, 1'b0);
    checkOutput("rst_sum",  sif.sum,  8'h00);
    checkOutput("rst_cout", sif.cout, 1'b0);
    checkOutput("rst_ovf",  sif.ovf,  1'b0);

    // Arithmetic cases.
    runOp("add",  1'b0, 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    runOp("addc", 1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0);
    runOp("sub1", 1'b1, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    runOp("sub2", 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start during RUN is ignored: pulse at RUN cycle 3 with other operands.
    applyStimulus(1'b0, 1'b0, 8'h5A, 8'h3C);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
    waitDone(edges, busyCount, overlap);
    checkOutput("ign_latency", edges, 5);
    checkOutput("ign_sum",  sif.sum,  8'h96);
    checkOutput("ign_cout", sif.cout, 1'b0);
    checkOutput("ign_ovf",  sif.ovf,  1'b1);

    // Back-to-back: start held across the done cycle and two RUN cycles.
    sif.start = 1'b1;
    sif.sub   = 1'b0;
    sif.cin   = 1'b0;
    sif.a     = 8'h01;
    sif.b     = 8'h02;
    tick();
    checkOutput("b2b_busy", sif.busy, 1'b1);
    checkOutput("b2b_old_sum", sif.sum, 8'h96);
    tick();
    tick();
    sif.start = 1'b0;
    waitDone(edges, busyCount, overlap);
    checkOutput("b2b_gap", edges + 3, 9);
    checkOutput("b2b_overlap", overlap, 0);
    checkOutput("b2b_sum",  sif.sum,  8'h03);
    checkOutput("b2b_cout", sif.cout, 1'b0);
    checkOutput("b2b_ovf",  sif.ovf,  1'b0);
    tick();

    // Reset mid-operation clears outputs without waiting for a clock edge.
    applyStimulus(1'b0, 1'b0, 8'h5A, 8'h3C);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", sif.busy, 1'b0);
    checkOutput("mid_rst_done", sif.done, 1'b0);
    checkOutput("mid_rst_sum",  sif.sum,  8'h00);
    checkOutput("mid_rst_cout", sif.cout, 1'b0);
    checkOutput("mid_rst_ovf",  sif.ovf,  1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_busy", sif.busy, 1'b0);
    runOp("post", 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
